// File: rtl/stopwatch_core.sv
// Centisecond stopwatch: 100 Hz prescaler, run/pause/clear FSM, 4-digit BCD SS.hh for the 7-seg driver.
// Optional lap/freeze display feature is enabled by defining STOPWATCH_LAP_EN.
module stopwatch_core #(
    parameter int TICK_DIV = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start_stop,
    input  logic        i_clear,
    input  logic        i_lap,
    output logic [15:0] o_data,
    output logic [1:0]  o_dot_pos,
    output logic        o_running,
    output logic        o_wrap
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESCALE_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t        state, state_next;
    logic [PW-1:0] prescale, prescale_next;
    logic [15:0]   count, count_next;
    logic [15:0]   data_next;
    logic          start_prev;
    logic          armed;
    logic          start_edge;
    logic          tick;
    logic          wrap_next;

    // One-digit-at-a-time ripple increment; a digit at 9 (or any illegal value) wraps and carries.
    function automatic logic [15:0] bcd_inc(input logic [15:0] value);
        logic [15:0] result;
        logic        carry;
        result = value;
        carry  = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (carry) begin
                if (value[d*4 +: 4] >= 4'd9) begin
                    result[d*4 +: 4] = 4'd0;
                end else begin
                    result[d*4 +: 4] = value[d*4 +: 4] + 4'd1;
                    carry            = 1'b0;
                end
            end
        end
        return result;
    endfunction

    // armed stays low for the first cycle out of reset so a level already high
    // at reset release is absorbed into the prev register instead of firing an edge.
    assign start_edge = i_start_stop & ~start_prev & armed;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_next    = state;
        prescale_next = prescale;
        count_next    = count;
        tick          = 1'b0;
        wrap_next     = 1'b0;

        if (i_clear) begin
            state_next    = IDLE;
            prescale_next = '0;
            count_next    = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    prescale_next = '0;
                    if (start_edge) state_next = RUN;
                end
                RUN: begin
                    if (prescale == PRESCALE_LAST) begin
                        prescale_next = '0;
                        tick          = 1'b1;
                    end else begin
                        prescale_next = prescale + PW'(1);
                    end
                    if (start_edge) state_next = PAUSE;
                end
                PAUSE: begin
                    if (start_edge) state_next = RUN;
                end
                default: state_next = IDLE;
            endcase

            if (tick) begin
                count_next = bcd_inc(count);
                wrap_next  = (count == 16'h9999);
            end
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic lap_prev;
    logic lap_edge;
    logic freeze;
    logic freeze_next;

    assign lap_edge = i_lap & ~lap_prev & armed;

    always_comb begin
        freeze_next = freeze;
        if (i_clear) begin
            freeze_next = 1'b0;
        end else if (lap_edge && state != IDLE) begin
            freeze_next = ~freeze;
        end
    end

    // While frozen the display register simply holds; releasing reloads the live count on that edge.
    assign data_next = freeze_next ? o_data : count_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lap_prev <= 1'b0;
            freeze   <= 1'b0;
        end else begin
            lap_prev <= i_lap;
            freeze   <= freeze_next;
        end
    end
`else
    logic unused_lap;
    assign unused_lap = i_lap;
    assign data_next  = count_next;
`endif

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state      <= IDLE;
            prescale   <= '0;
            count      <= '0;
            start_prev <= 1'b0;
            armed      <= 1'b0;
            o_data     <= '0;
            o_running  <= 1'b0;
            o_wrap     <= 1'b0;
        end else begin
            state      <= state_next;
            prescale   <= prescale_next;
            count      <= count_next;
            start_prev <= i_start_stop;
            armed      <= 1'b1;
            o_data     <= data_next;
            o_running  <= (state_next == RUN);
            o_wrap     <= wrap_next;
        end
    end

    assign o_dot_pos = 2'd2;

endmodule
